demo_req_sequencer: RTL
=======================

Name: demo_req_sequencer

Overview:
Front-end stage that turns the board-level demo controls (active-low start button, mode switch) into one well-formed bus request for the demo initiator. It then waits for the response.
- Synchronizes and debounces the raw inputs.
- Detects the start press on its falling edge and latches the mode at press time.
- Issues a single valid/ready request, waits for the response, and reflects status and read data on the demo LEDs.
- Sits directly upstream of the demo bus initiator inside dual_bus_top.

Parameters:
- DEBOUNCE_CYCLES, default 1: number of consecutive identical synchronized samples required before the debounced level changes. Minimum 1.
- TIMEOUT_CYCLES, default 1024: cycles spent in WAIT_RSP before the transaction is abandoned.
- ADDR_WIDTH, default 12: request address width.
- DATA_WIDTH, default 8: request/response data width.
- DEMO_ADDR, default 12'h010: fixed target address of every demo transaction.
- WDATA_SEED, default 8'hA5: write data used for the first write after reset.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- demo_start  in  1  raw start button, active-low; a press is a falling edge
- demo_mode  in  1  raw mode switch; 1 = write, 0 = read
- req_valid  out  1  request valid to the initiator
- req_ready  in  1  initiator accepts the request
- req_write  out  1  1 = write, 0 = read
- req_addr  out  ADDR_WIDTH  request address
- req_wdata  out  DATA_WIDTH  write data
- rsp_valid  in  1  single-cycle response strobe from the initiator
- rsp_rdata  in  DATA_WIDTH  read data, valid with rsp_valid
- demo_ready  out  1  high in IDLE, i.e. a new press will be accepted
- leds_demo  out  8  status/data display

Behaviour:
Input conditioning
- demo_start and demo_mode each pass through a 2-flop synchronizer. Both synchronizers reset to 1.
- Debounce on start: a counter tracks how long the synchronized value has differed from the debounced level.
  - The debounced level takes the new value once the value has been stable for DEBOUNCE_CYCLES samples.
  - The counter clears on any mismatch glitch.
  - The debounced level resets to 1.
- A press is debounced 1 -> 0. It produces a 1-cycle internal start pulse.
- The mode value is captured from the synchronized mode in the same cycle as the start pulse.

FSM states: IDLE, ISSUE, WAIT_RSP, DONE. Reset state is IDLE.
- IDLE:
  - On the start pulse: latch req_write = captured mode, req_addr = DEMO_ADDR, req_wdata = wdata register; go to ISSUE.
- ISSUE:
  - req_valid = 1. req_write, req_addr and req_wdata are held stable.
  - Leave only on a clock edge where req_valid && req_ready; go to WAIT_RSP and clear the timeout counter.
  - There is no timeout in ISSUE; req_ready may stay low indefinitely.
- WAIT_RSP:
  - On rsp_valid:
    - For a read, capture rsp_rdata into leds_demo.
    - For a write, set leds_demo = {4'b0001, txn_count[3:0]} and increment the wdata register (8-bit wrap, FF -> 00).
    - Increment txn_count (4-bit, wraps 15 -> 0).
    - Go to DONE.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without rsp_valid: leds_demo = 8'hEE, wdata unchanged, txn_count unchanged; go to DONE.
- DONE:
  - One cycle, then go to IDLE.
- rsp_valid in any state other than WAIT_RSP is ignored.

Other rules
- Presses while not in IDLE are dropped, not queued. The debounce logic still tracks the level, so the release followed by a new press is recognized after return to IDLE.
- A start pulse in the same cycle as DONE -> IDLE is dropped.
- Latency, press to request: req_valid rises on the (3+DEBOUNCE_CYCLES)-th rising edge after the first edge that samples demo_start low. This is 4 edges for the default.
- A 1-cycle low pulse on demo_start is a valid press when DEBOUNCE_CYCLES = 1.
- demo_ready = (state == IDLE), registered from the state.

Reset values, applied asynchronously: req_valid 0, req_write 0, req_addr 0, req_wdata 0, demo_ready 1 (IDLE), leds_demo 8'h00, wdata register WDATA_SEED, txn_count 0.
- Reset mid-transaction drops req_valid immediately. No partial LED update occurs.

Test Plan:
- Reset, hold demo_start=1 and demo_mode=1, then pulse demo_start low for 1 cycle -> req_valid=1, req_write=1, req_addr=12'h010, req_wdata=8'hA5 at edge 4. demo_ready=0.
- With req_ready held low for 10 cycles and then raised -> req_valid stays high with constant payload and drops on the cycle after the handshake. rsp_valid then gives leds_demo=8'h10 and demo_ready=1 two cycles later.
- Second write, then a read with rsp_rdata=8'h3C -> second write carries req_wdata=8'hA6, read has req_write=0, and leds_demo=8'h3C after the response.
- Second press during WAIT_RSP -> no additional req_valid. Exactly one transaction completes, and txn_count increments by 1.
- No rsp_valid with TIMEOUT_CYCLES=16 -> leds_demo=8'hEE 16 cycles after the handshake, return to IDLE, next write still uses the same wdata.
- Assert rst_n=0 while in ISSUE -> req_valid=0 without waiting for a clock edge. After release, leds_demo=0, demo_ready=1, and the first write again uses 8'hA5.

Source files
------------

// File: rtl/demo_req_sequencer.sv
// demo_req_sequencer
// Turns the board demo controls (active-low start button, mode switch) into a
// single valid/ready bus request, waits for the response (or a timeout) and
// shows the outcome on the demo LEDs.
module demo_req_sequencer #(
   parameter int unsigned            DEBOUNCE_CYCLES = 1,
   parameter int unsigned            TIMEOUT_CYCLES  = 1024,
   parameter int unsigned            ADDR_WIDTH      = 12,
   parameter int unsigned            DATA_WIDTH      = 8,
   parameter logic [ADDR_WIDTH-1:0]  DEMO_ADDR       = ADDR_WIDTH'('h010),
   parameter logic [DATA_WIDTH-1:0]  WDATA_SEED      = DATA_WIDTH'('hA5)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  demo_start,
   input  logic                  demo_mode,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic                  req_write,
   output logic [ADDR_WIDTH-1:0] req_addr,
   output logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  rsp_valid,
   input  logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  demo_ready,
   output logic [7:0]            leds_demo
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t                state;
   logic                  start_meta, start_sync;
   logic                  mode_meta, mode_sync;
   logic                  start_deb, start_deb_d;
   logic [DB_W-1:0]       db_cnt;
   logic [TO_W-1:0]       to_cnt;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [3:0]            txn_count;
   logic                  start_pulse;

   // Synchronize both raw inputs and debounce the start button level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_meta  <= 1'b1;
         start_sync  <= 1'b1;
         mode_meta   <= 1'b1;
         mode_sync   <= 1'b1;
         start_deb   <= 1'b1;
         start_deb_d <= 1'b1;
         db_cnt      <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge
         // value, which is what makes the two-flop chain a real synchronizer.
         start_meta  <= demo_start;
         start_sync  <= start_meta;
         mode_meta   <= demo_mode;
         mode_sync   <= mode_meta;
         start_deb_d <= start_deb;
         if (start_sync != start_deb) begin
            if (db_cnt == DB_LAST) begin
               start_deb <= start_sync;
               db_cnt    <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // A press is the debounced level falling 1 -> 0; lasts exactly one cycle.
   assign start_pulse = start_deb_d & ~start_deb;

   // Transaction FSM with all bus and status outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_valid  <= 1'b0;
         req_write  <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         demo_ready <= 1'b1;
         leds_demo  <= 8'h00;
         wdata_reg  <= WDATA_SEED;
         txn_count  <= 4'd0;
         to_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_pulse) begin
                  req_write  <= mode_sync;
                  req_addr   <= DEMO_ADDR;
                  req_wdata  <= wdata_reg;
                  req_valid  <= 1'b1;
                  demo_ready <= 1'b0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               // Payload is held; no timeout here, the initiator may stall.
               if (req_ready) begin
                  req_valid <= 1'b0;
                  to_cnt    <= '0;
                  state     <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (rsp_valid) begin
                  if (req_write) begin
                     leds_demo <= {4'b0001, txn_count};
                     wdata_reg <= wdata_reg + 1'b1;
                  end else begin
                     leds_demo <= 8'(rsp_rdata);
                  end
                  txn_count <= txn_count + 4'd1;
                  state     <= DONE;
               end else if (to_cnt == TO_LAST) begin
                  leds_demo <= 8'hEE;
                  state     <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            DONE: begin
               // Any start pulse seen here is intentionally dropped.
               demo_ready <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               demo_ready <= 1'b1;
               req_valid  <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
